hex_ascii_uart_streamer: RTL and testbench



---
 rtl/hex_ascii_uart_streamer_pkg.sv | 26 ++
 rtl/hex_ascii_uart_streamer_uart_tx.sv | 82 ++++++++
 rtl/hex_ascii_uart_streamer.sv | 113 +++++++++++
 tb/tb_hex_ascii_uart_streamer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hex_ascii_uart_streamer_pkg.sv
// Shared constants for the hex-ASCII UART streamer: line terminators,
// FSM encodings for the message sequencer and the 8N1 transmitter.
package hex_ascii_uart_streamer_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOAD    = 2'd1;
    localparam logic [1:0] ST_WAIT_TX = 2'd2;
    localparam logic [1:0] ST_FINISH  = 2'd3;

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    // Width needed to hold values 0..value-1, never less than one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/hex_ascii_uart_streamer_uart_tx.sv
// 8N1 UART transmitter. A new byte may be issued during the last cycle of
// the stop bit (frame_done) so consecutive frames run back-to-back.
module uart_tx_8n1
    import hex_ascii_uart_streamer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready,
    output logic       frame_done
);

    localparam int BW = clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    logic [1:0]    state;
    logic [BW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          bit_end;
    logic          accept;

    assign bit_end    = (baud_cnt == BAUD_LAST);
    assign ready      = (state == TX_IDLE);
    assign frame_done = (state == TX_STOP) && bit_end;
    assign accept     = send && (ready || frame_done);

    // bit_cnt: 0 = start bit, 1..8 = data bits, 9 = stop bit
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= TX_IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (accept) begin
            state    <= TX_START;
            tx       <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (state != TX_IDLE) begin
            if (bit_end) begin
                baud_cnt <= '0;
                case (state)
                    TX_START: begin
                        state   <= TX_DATA;
                        tx      <= shreg[0];
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                    TX_DATA: begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd8) begin
                            state <= TX_STOP;
                            tx    <= 1'b1;
                        end else begin
                            tx <= shreg[0];
                        end
                    end
                    default: begin
                        state   <= TX_IDLE;
                        tx      <= 1'b1;
                        bit_cnt <= '0;
                    end
                endcase
            end else begin
                baud_cnt <= baud_cnt + BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            shreg <= data;
        end else if (bit_end && (state == TX_START || state == TX_DATA)) begin
            shreg <= shreg >> 1;
        end
    end

endmodule

// File: rtl/hex_ascii_uart_streamer.sv
// Latches a packed ASCII string on start and streams it, highest byte first,
// over an 8N1 UART line, optionally followed by CR LF.
module hex_ascii_uart_streamer
    import hex_ascii_uart_streamer_pkg::*;
#(
    parameter int CLK_FREQ    = 50000000,
    parameter int BAUD        = 115200,
    parameter int NUM_CHARS   = 2,
    parameter int APPEND_CRLF = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [8*NUM_CHARS-1:0] ascii_in,
    output logic                   busy,
    output logic                   done,
    output logic                   tx
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int TOTAL        = NUM_CHARS + 2 * APPEND_CRLF;
    localparam int CW           = clog2(NUM_CHARS + 2);
    localparam logic [CW-1:0] LAST_IDX = CW'(TOTAL - 1);
    localparam logic [CW-1:0] NUM_IDX  = CW'(NUM_CHARS);

    logic [1:0]             state;
    logic [CW-1:0]          char_idx;
    logic [CW-1:0]          next_idx;
    logic [8*NUM_CHARS-1:0] char_buf;
    logic [7:0]             next_char;
    logic [7:0]             send_data;
    logic                   send;
    logic                   accept;
    logic                   issue;
    logic                   more;
    logic                   tx_ready;
    logic                   frame_done;

    // FINISH behaves as idle so a held start restarts after one idle cycle
    assign accept   = start && tx_ready && (state == ST_IDLE || state == ST_FINISH);
    assign more     = (char_idx != LAST_IDX);
    assign issue    = (state == ST_WAIT_TX) && frame_done && more;
    assign next_idx = char_idx + CW'(1);
    assign send     = accept || issue;

    always_comb begin
        next_char = ASCII_LF;
        if (next_idx < NUM_IDX) begin
            next_char = char_buf[8*NUM_CHARS-1 -: 8];
        end else if (next_idx == NUM_IDX) begin
            next_char = ASCII_CR;
        end
    end

    assign send_data = accept ? ascii_in[8*NUM_CHARS-1 -: 8] : next_char;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            char_idx <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_FINISH: begin
                    if (accept) begin
                        state    <= ST_LOAD;
                        char_idx <= '0;
                        busy     <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_LOAD: state <= ST_WAIT_TX;
                default: begin
                    if (frame_done) begin
                        if (more) begin
                            state    <= ST_LOAD;
                            char_idx <= next_idx;
                        end else begin
                            state <= ST_FINISH;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Buffer always holds the next string character in its top byte
    always_ff @(posedge clk) begin
        if (accept) begin
            char_buf <= ascii_in << 8;
        end else if (issue) begin
            char_buf <= char_buf << 8;
        end
    end

    uart_tx_8n1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk       (clk),
        .rst       (rst),
        .send      (send),
        .data      (send_data),
        .tx        (tx),
        .ready     (tx_ready),
        .frame_done(frame_done)
    );

endmodule

// File: tb/tb_hex_ascii_uart_streamer.sv
// Bench for hex_ascii_uart_streamer: three configurations share one UART
// decoder and a scoreboard queue of expected bytes; one DUT is active at a time.
module tb_hex_ascii_uart_streamer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] ascii = '0;
    int          sel = 0;

    logic tx0, tx1, tx2, busy0, busy1, busy2, done0, done1, done2;
    logic tx_m, busy_m, done_m;

    always #5 clk = ~clk;

    hex_ascii_uart_streamer #(.CLK_FREQ(1000), .BAUD(250), .NUM_CHARS(2), .APPEND_CRLF(0)) dut0 (
        .clk(clk), .rst(rst), .start(start && sel == 0), .ascii_in(ascii[15:0]),
        .busy(busy0), .done(done0), .tx(tx0));
    hex_ascii_uart_streamer #(.CLK_FREQ(1000), .BAUD(250), .NUM_CHARS(2), .APPEND_CRLF(1)) dut1 (
        .clk(clk), .rst(rst), .start(start && sel == 1), .ascii_in(ascii[15:0]),
        .busy(busy1), .done(done1), .tx(tx1));
    hex_ascii_uart_streamer #(.CLK_FREQ(1000), .BAUD(250), .NUM_CHARS(8), .APPEND_CRLF(0)) dut2 (
        .clk(clk), .rst(rst), .start(start && sel == 2), .ascii_in(ascii),
        .busy(busy2), .done(done2), .tx(tx2));

    always_comb begin
        case (sel)
            1:       begin tx_m = tx1; busy_m = busy1; done_m = done1; end
            2:       begin tx_m = tx2; busy_m = busy2; done_m = done2; end
            default: begin tx_m = tx0; busy_m = busy0; done_m = done0; end
        endcase
    end

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         rst_gen = 0;
    logic [7:0] exp_q[$];
    int         done_q[$];
    logic       done_tx_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done_m === 1'b1) begin
            done_q.push_back(cyc);
            done_tx_q.push_back(tx_m);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // UART decoder: samples the middle (third cycle) of every bit
    initial begin : uart_monitor
        logic [7:0] rx;
        logic       stop;
        int         gen;
        forever begin
            @(negedge clk);
            if (tx_m === 1'b0 && rst === 1'b0) begin
                gen = rst_gen;
                repeat (2) @(negedge clk);
                for (int b = 0; b < 8; b++) begin
                    repeat (4) @(negedge clk);
                    rx[b] = tx_m;
                end
                repeat (4) @(negedge clk);
                stop = tx_m;
                if (gen == rst_gen) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL uart_byte: got %0h expected no byte", rx);
                    end else begin
                        chk("uart_byte", rx, exp_q.pop_front());
                        chk("stop_bit", stop, 1);
                    end
                end
            end
        end
    end

    task automatic send_msg(input int s, input logic [63:0] d, input int exp_len,
                            input int poke_at, input int abort_at);
        int  busy_n;
        bit  got;
        sel = s;
        ascii = d;
        busy_n = 0;
        got = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("accept_tx", tx_m, 0);
        chk("accept_busy", busy_m, 1);
        if (busy_m === 1'b1) busy_n++;
        for (int c = 1; c <= exp_len + 10 && !got; c++) begin
            @(negedge clk);
            if (poke_at != 0 && c == poke_at) begin
                ascii = 64'h4646;
                start = 1'b1;
            end
            if (poke_at != 0 && c == poke_at + 5) start = 1'b0;
            if (abort_at != 0 && c == abort_at) begin
                rst = 1'b1;
                rst_gen++;
                @(negedge clk);
                chk("abort_tx", tx_m, 1);
                chk("abort_busy", busy_m, 0);
                chk("abort_done", done_m, 0);
                rst = 1'b0;
                exp_q.delete();
                return;
            end
            if (busy_m === 1'b1) busy_n++;
            if (done_m === 1'b1) begin
                got = 1;
                chk("done_cycle", c, exp_len);
                chk("busy_cycles", busy_n, exp_len);
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected at cycle %0d", exp_len);
        end
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        repeat (3) @(negedge clk);
        chk("rst_tx0", tx0, 1);     chk("rst_busy0", busy0, 0); chk("rst_done0", done0, 0);
        chk("rst_tx1", tx1, 1);     chk("rst_busy1", busy1, 0); chk("rst_done1", done1, 0);
        chk("rst_tx2", tx2, 1);     chk("rst_busy2", busy2, 0); chk("rst_done2", done2, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // two characters, no terminator
        d0 = done_q.size();
        exp_q.push_back(8'h37); exp_q.push_back(8'h41);
        send_msg(0, 64'h3741, 80, 0, 0);
        repeat (10) @(negedge clk);
        chk("t1_queue_empty", exp_q.size(), 0);
        chk("t1_done_count", done_q.size() - d0, 1);

        // CR LF appended
        d0 = done_q.size();
        exp_q.push_back(8'h37); exp_q.push_back(8'h41);
        exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        send_msg(1, 64'h3741, 160, 0, 0);
        repeat (10) @(negedge clk);
        chk("t2_queue_empty", exp_q.size(), 0);
        chk("t2_done_count", done_q.size() - d0, 1);

        // start and new data while busy are ignored
        d0 = done_q.size();
        exp_q.push_back(8'h37); exp_q.push_back(8'h41);
        send_msg(0, 64'h3741, 80, 20, 0);
        repeat (100) @(negedge clk);
        chk("t3_queue_empty", exp_q.size(), 0);
        chk("t3_done_count", done_q.size() - d0, 1);

        // reset mid-message, then a clean message
        d0 = done_q.size();
        exp_q.push_back(8'h37); exp_q.push_back(8'h41);
        send_msg(0, 64'h3741, 80, 0, 30);
        repeat (80) @(negedge clk);
        chk("t4_no_done", done_q.size() - d0, 0);
        exp_q.push_back(8'h30); exp_q.push_back(8'h30);
        send_msg(0, 64'h3030, 80, 0, 0);
        repeat (10) @(negedge clk);
        chk("t4_queue_empty", exp_q.size(), 0);

        // start held high: three messages, one idle cycle between them
        sel = 0;
        ascii = 64'h3741;
        done_q.delete();
        done_tx_q.delete();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'h37); exp_q.push_back(8'h41);
        end
        @(negedge clk);
        start = 1'b1;
        for (int c = 0; c < 400 && done_q.size() < 2; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 200 && done_q.size() < 3; c++) @(negedge clk);
        repeat (20) @(negedge clk);
        chk("t5_done_count", done_q.size(), 3);
        if (done_q.size() >= 3) begin
            chk("t5_gap_1", done_q[1] - done_q[0], 81);
            chk("t5_gap_2", done_q[2] - done_q[1], 81);
            chk("t5_idle_tx_1", done_tx_q[0], 1);
            chk("t5_idle_tx_2", done_tx_q[1], 1);
        end
        chk("t5_queue_empty", exp_q.size(), 0);

        // eight characters "DEADBEEF"
        d0 = done_q.size();
        exp_q.push_back(8'h44); exp_q.push_back(8'h45);
        exp_q.push_back(8'h41); exp_q.push_back(8'h44);
        exp_q.push_back(8'h42); exp_q.push_back(8'h45);
        exp_q.push_back(8'h45); exp_q.push_back(8'h46);
        send_msg(2, 64'h4445414442454546, 320, 0, 0);
        repeat (10) @(negedge clk);
        chk("t6_queue_empty", exp_q.size(), 0);
        chk("t6_done_count", done_q.size() - d0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
